// File: rtl/rf_pkg.sv
// Shared state encoding and constants for the regfile access controller.
package rf_pkg;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_RESP
    } rf_state_t;

    localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/regfile_access_ctrl_if.sv
// Decode / operand / writeback / regfile-port bundle for the access controller.
interface regfile_access_ctrl_if #(
    parameter int AWIDTH = 8,
    parameter int DWIDTH = 16
);
    logic              dec_valid;
    logic              dec_ready;
    logic [AWIDTH-1:0] dec_rs_addr;
    logic [AWIDTH-1:0] dec_rt_addr;
    logic              dec_use_rs;
    logic              dec_use_rt;
    logic              out_valid;
    logic              out_ready;
    logic [DWIDTH-1:0] out_rs_data;
    logic [DWIDTH-1:0] out_rt_data;
    logic              wb_valid;
    logic              wb_ready;
    logic [AWIDTH-1:0] wb_addr;
    logic [DWIDTH-1:0] wb_data;
    logic              rf_clear;
    logic [AWIDTH-1:0] rf_addr_rs;
    logic              rf_req_rs;
    logic [AWIDTH-1:0] rf_addr_rt;
    logic              rf_req_rt;
    logic [AWIDTH-1:0] rf_addr_rd;
    logic              rf_req_rd;
    logic [DWIDTH-1:0] rf_wdata;
    logic [DWIDTH-1:0] rf_rs;
    logic [DWIDTH-1:0] rf_rt;

    modport slave (
        input  dec_valid, dec_rs_addr, dec_rt_addr, dec_use_rs, dec_use_rt,
        input  out_ready, wb_valid, wb_addr, wb_data, rf_rs, rf_rt,
        output dec_ready, out_valid, out_rs_data, out_rt_data, wb_ready,
        output rf_clear, rf_addr_rs, rf_req_rs, rf_addr_rt, rf_req_rt,
        output rf_addr_rd, rf_req_rd, rf_wdata
    );

    modport master (
        output dec_valid, dec_rs_addr, dec_rt_addr, dec_use_rs, dec_use_rt,
        output out_ready, wb_valid, wb_addr, wb_data, rf_rs, rf_rt,
        input  dec_ready, out_valid, out_rs_data, out_rt_data, wb_ready,
        input  rf_clear, rf_addr_rs, rf_req_rs, rf_addr_rt, rf_req_rt,
        input  rf_addr_rd, rf_req_rd, rf_wdata
    );
endinterface

// File: rtl/rf_wb_fifo.sv
// Writeback queue: {addr,data} ring buffer exposing per-entry valid/addr for hazard compares.
module rf_wb_fifo
    import rf_pkg::*;
#(
    parameter int AWIDTH = 8,
    parameter int DWIDTH = 16,
    parameter int DEPTH  = 2
) (
    input  logic                         clk,
    input  logic                         clear,
    input  logic                         push,
    input  logic [AWIDTH-1:0]            push_addr,
    input  logic [DWIDTH-1:0]            push_data,
    input  logic                         pop,
    output logic                         full,
    output logic                         empty,
    output logic [AWIDTH-1:0]            head_addr,
    output logic [DWIDTH-1:0]            head_data,
    output logic [DEPTH-1:0]             ent_valid,
    output logic [DEPTH-1:0][AWIDTH-1:0] ent_addr
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0][AWIDTH-1:0] addr_q;
    logic [DEPTH-1:0][DWIDTH-1:0] data_q;
    logic [PW-1:0]                wr_ptr;
    logic [PW-1:0]                rd_ptr;
    logic [CW-1:0]                count;
    logic                         do_push;
    logic                         do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Payload needs no reset: occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_q[wr_ptr] <= push_addr;
            data_q[wr_ptr] <= push_data;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic [PW-1:0] ofs;
        assign ofs          = PW'(i) - rd_ptr;
        assign ent_valid[i] = (CW'(ofs) < count);
    end

    assign ent_addr  = addr_q;
    assign head_addr = addr_q[rd_ptr];
    assign head_data = data_q[rd_ptr];

endmodule

// File: rtl/regfile_access_ctrl.sv
// Regfile port initiator: operand reads with 1-cycle latency, queued writebacks, RAW stall, clear sequencing.
module regfile_access_ctrl
    import rf_pkg::*;
#(
    parameter int AWIDTH   = 8,
    parameter int DWIDTH   = 16,
    parameter int WB_DEPTH = 2
) (
    input logic                 clk,
    input logic                 clear,
    regfile_access_ctrl_if.slave bus
);
    localparam logic [AWIDTH-1:0] ZERO = AWIDTH'(REG_ZERO);

    rf_state_t                       state, state_nxt;
    logic                            fifo_full, fifo_empty;
    logic [AWIDTH-1:0]               head_addr;
    logic [DWIDTH-1:0]               head_data;
    logic [WB_DEPTH-1:0]             ent_valid;
    logic [WB_DEPTH-1:0][AWIDTH-1:0] ent_addr;
    logic                            wb_push, rs_need, rt_need, hazard, accept;
    logic                            fresh_q, rs_used_q, rt_used_q;
    logic [DWIDTH-1:0]               rs_hold, rt_hold;

    rf_wb_fifo #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .DEPTH(WB_DEPTH)) u_wb_fifo (
        .clk       (clk),
        .clear     (clear),
        .push      (wb_push),
        .push_addr (bus.wb_addr),
        .push_data (bus.wb_data),
        .pop       (1'b1),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_addr (head_addr),
        .head_data (head_data),
        .ent_valid (ent_valid),
        .ent_addr  (ent_addr)
    );

    assign bus.wb_ready = (state != ST_INIT) && !fifo_full;
    assign wb_push      = bus.wb_valid && bus.wb_ready && (bus.wb_addr != ZERO);
    assign rs_need      = bus.dec_use_rs && (bus.dec_rs_addr != ZERO);
    assign rt_need      = bus.dec_use_rt && (bus.dec_rt_addr != ZERO);

    // No bypass: any queued or incoming write to a needed source stalls decode.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            if (ent_valid[i] && rs_need && ent_addr[i] == bus.dec_rs_addr) hazard = 1'b1;
            if (ent_valid[i] && rt_need && ent_addr[i] == bus.dec_rt_addr) hazard = 1'b1;
        end
        if (wb_push && rs_need && bus.wb_addr == bus.dec_rs_addr) hazard = 1'b1;
        if (wb_push && rt_need && bus.wb_addr == bus.dec_rt_addr) hazard = 1'b1;
    end

    always_comb begin
        state_nxt     = state;
        bus.dec_ready = 1'b0;
        case (state)
            ST_INIT: state_nxt = ST_IDLE;
            ST_IDLE: begin
                bus.dec_ready = !hazard;
                if (bus.dec_valid && !hazard) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                bus.dec_ready = bus.out_ready && !hazard;
                if (bus.out_ready && !(bus.dec_valid && !hazard)) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    assign accept = bus.dec_valid && bus.dec_ready;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state     <= ST_INIT;
            fresh_q   <= 1'b0;
            rs_used_q <= 1'b0;
            rt_used_q <= 1'b0;
            rs_hold   <= '0;
            rt_hold   <= '0;
        end else begin
            state   <= state_nxt;
            fresh_q <= accept;
            if (accept) begin
                rs_used_q <= rs_need;
                rt_used_q <= rt_need;
            end
            rs_hold <= bus.out_rs_data;
            rt_hold <= bus.out_rt_data;
        end
    end

    // Regfile data is only trusted the cycle after the request; afterwards replay the captured copy.
    assign bus.out_valid   = (state == ST_RESP);
    assign bus.out_rs_data = !fresh_q ? rs_hold : (rs_used_q ? bus.rf_rs : '0);
    assign bus.out_rt_data = !fresh_q ? rt_hold : (rt_used_q ? bus.rf_rt : '0);

    assign bus.rf_clear   = (state == ST_INIT);
    assign bus.rf_req_rs  = accept && rs_need;
    assign bus.rf_addr_rs = bus.dec_rs_addr;
    assign bus.rf_req_rt  = accept && rt_need;
    assign bus.rf_addr_rt = bus.dec_rt_addr;
    assign bus.rf_req_rd  = !fifo_empty;
    assign bus.rf_addr_rd = head_addr;
    assign bus.rf_wdata   = head_data;

endmodule
